// File: rtl/period_pkg.sv
// Constants shared by the period measurement and generation blocks of the PLL model.
package period_pkg;

    localparam int unsigned PERIOD_SCALE            = 1000;
    localparam int unsigned DEFAULT_MIN_PERIOD_1000 = 2000;

endpackage

// File: rtl/period_gen_phase_acc.sv
// Phase accumulator: adds one clk worth of thousandths per edge and toggles the output
// whenever the current half-phase target is reached, carrying the remainder forward.
module phase_acc
    import period_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_apply,
    input  logic             i_apply_level,
    input  logic             i_run,
    input  logic [WIDTH-1:0] i_h_hi,
    input  logic [WIDTH-1:0] i_h_lo,
    output logic             o_clk_out,
    output logic             o_rise_due
);

    logic [WIDTH:0] r_acc;
    logic           r_clk_out;

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_target;
    logic           w_toggle;

    // acc stays below the largest half-phase, so one extra bit keeps the sum from wrapping
    assign w_sum      = r_acc + (WIDTH+1)'(PERIOD_SCALE);
    assign w_target   = {1'b0, (r_clk_out ? i_h_hi : i_h_lo)};
    assign w_toggle   = (w_sum >= w_target);
    assign o_rise_due = !r_clk_out && w_toggle;
    assign o_clk_out  = r_clk_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_clk_out <= 1'b0;
        end else if (i_clear) begin
            r_acc     <= '0;
            r_clk_out <= 1'b0;
        end else if (i_apply) begin
            r_acc     <= '0;
            r_clk_out <= i_apply_level;
        end else if (i_run) begin
            if (w_toggle) begin
                r_clk_out <= ~r_clk_out;
                r_acc     <= w_sum - w_target;
            end else begin
                r_acc     <= w_sum;
            end
        end
    end

endmodule

// File: rtl/period_gen.sv
// Fractional clock-period generator: holds pending/active period registers and switches
// periods only at rising-edge boundaries of the generated clock.
module period_gen
    import period_pkg::*;
#(
    parameter int          WIDTH           = 32,
    parameter int unsigned MIN_PERIOD_1000 = period_pkg::DEFAULT_MIN_PERIOD_1000
) (
    input  logic             clk,
    input  logic             RST_N,
    input  logic             PWRDWN,
    input  logic [WIDTH-1:0] period_length_1000,
    input  logic             load,
    output logic             clk_out,
    output logic [WIDTH-1:0] period_active_1000,
    output logic             busy,
    output logic             err
);

    logic [WIDTH-1:0] r_active;
    logic [WIDTH-1:0] r_pending;
    logic             r_busy;
    logic             r_err;

    logic             w_load_ok;
    logic             w_load_bad;
    logic             w_idle;
    logic             w_rise_due;
    logic             w_apply;
    logic             w_clear;
    logic [WIDTH-1:0] w_h_hi;
    logic [WIDTH-1:0] w_h_lo;

    assign w_load_ok  = load && ((period_length_1000 == '0) ||
                                 (period_length_1000 >= WIDTH'(MIN_PERIOD_1000)));
    assign w_load_bad = load && !w_load_ok;
    assign w_idle     = (r_active == '0);
    assign w_h_hi     = r_active >> 1;
    assign w_h_lo     = r_active - w_h_hi;

    // Apply points: any edge while idle, or the edge that would start a new high phase.
    assign w_apply = !PWRDWN && r_busy && (w_idle || w_rise_due);
    assign w_clear = PWRDWN || (w_idle && !r_busy);

    phase_acc #(
        .WIDTH (WIDTH)
    ) u_phase_acc (
        .clk           (clk),
        .rst_n         (RST_N),
        .i_clear       (w_clear),
        .i_apply       (w_apply),
        .i_apply_level (r_pending != '0),
        .i_run         (!w_idle),
        .i_h_hi        (w_h_hi),
        .i_h_lo        (w_h_lo),
        .o_clk_out     (clk_out),
        .o_rise_due    (w_rise_due)
    );

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            r_active  <= '0;
            r_pending <= '0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_err <= w_load_bad;
            // NOTE: non-blocking assignment lets an apply on the same edge as a load
            // pick up the old pending value while the new one is captured.
            if (w_apply)
                r_active <= r_pending;
            if (w_load_ok)
                r_pending <= period_length_1000;
            if (w_load_ok)
                r_busy <= 1'b1;
            else if (w_apply)
                r_busy <= 1'b0;
        end
    end

    assign period_active_1000 = r_active;
    assign busy               = r_busy;
    assign err                = r_err;

endmodule

// File: tb/tb_period_gen.sv
// Self-checking bench for period_gen: directed scenarios plus random periods compared
// against an arithmetic model of where each half-phase boundary falls.
module tb_period_gen;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             RST_N = 1'b0;
    logic             PWRDWN = 1'b0;
    logic [WIDTH-1:0] period_length_1000 = '0;
    logic             load = 1'b0;
    logic             clk_out;
    logic [WIDTH-1:0] period_active_1000;
    logic             busy;
    logic             err;

    int n_checks = 0;
    int n_pass   = 0;

    period_gen #(.WIDTH(WIDTH)) dut (
        .clk                (clk),
        .RST_N              (RST_N),
        .PWRDWN             (PWRDWN),
        .period_length_1000 (period_length_1000),
        .load               (load),
        .clk_out            (clk_out),
        .period_active_1000 (period_active_1000),
        .busy               (busy),
        .err                (err)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1);
    end

    // Expected clk_out m edges after a rise (m=0 is the rise). Half-phase boundary j
    // lands on the first edge whose elapsed thousandths reach the cumulative target.
    function automatic logic model_level(input longint per, input int m);
        longint c, nxt;
        int n;
        bit done;
        c = 0; n = 0; done = 0;
        while (!done) begin
            nxt = c + (((n % 2) == 0) ? (per / 2) : (per - per / 2));
            if (((nxt + 999) / 1000) > m) done = 1;
            else begin c = nxt; n++; end
        end
        return ((n % 2) == 0);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [WIDTH-1:0] v);
        period_length_1000 = v;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic reset_dut();
        RST_N = 1'b0;
        PWRDWN = 1'b0;
        load = 1'b0;
        #3;
        RST_N = 1'b1;
    endtask

    // Start a period from idle; leaves the bench at the rise edge (m = 0).
    task automatic start_period(input logic [WIDTH-1:0] per);
        reset_dut();
        do_load(per);
        step();
        n_checks++;
        if (clk_out !== 1'b1 || period_active_1000 !== per)
            $display("FAIL start_rise clk_out=%b active=%0d want 1/%0d", clk_out, period_active_1000, per);
        else n_pass++;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (clk_out !== 1'b0 || period_active_1000 !== '0 || busy !== 1'b0 || err !== 1'b0)
            $display("FAIL reset_state clk_out=%b active=%0d busy=%b err=%b want all 0",
                     clk_out, period_active_1000, busy, err);
        else n_pass++;
        RST_N = 1'b1;
        step();
    endtask

    task automatic test_basic_10000();
        reset_dut();
        do_load(32'd10000);
        n_checks++;
        if (busy !== 1'b1 || clk_out !== 1'b0)
            $display("FAIL basic_load busy=%b clk_out=%b want 1/0", busy, clk_out);
        else n_pass++;
        step();
        n_checks++;
        if (clk_out !== 1'b1 || busy !== 1'b0 || period_active_1000 !== 32'd10000)
            $display("FAIL basic_apply clk_out=%b busy=%b active=%0d want 1/0/10000",
                     clk_out, busy, period_active_1000);
        else n_pass++;
        for (int m = 1; m <= 40; m++) begin
            step();
            n_checks++;
            if (clk_out !== (((m % 10) < 5) ? 1'b1 : 1'b0))
                $display("FAIL basic_wave m=%0d clk_out=%b", m, clk_out);
            else n_pass++;
        end
    endtask

    task automatic test_3000();
        start_period(32'd3000);
        for (int m = 1; m <= 30; m++) begin
            step();
            n_checks++;
            if (clk_out !== (((m % 3) < 2) ? 1'b1 : 1'b0))
                $display("FAIL p3000_wave m=%0d clk_out=%b", m, clk_out);
            else n_pass++;
        end
    endtask

    task automatic test_2500();
        int rises;
        start_period(32'd2500);
        rises = 1;
        for (int m = 1; m < 20; m++) begin
            logic prev;
            prev = clk_out;
            step();
            if (!prev && clk_out) rises++;
        end
        n_checks++;
        if (rises !== 8) $display("FAIL p2500_rises got %0d want 8", rises);
        else n_pass++;
    endtask

    task automatic test_change_mid_high();
        int rises;
        logic prev;
        start_period(32'd10000);
        step(); step();
        do_load(32'd13000);
        n_checks++;
        if (busy !== 1'b1 || period_active_1000 !== 32'd10000 || clk_out !== 1'b1)
            $display("FAIL chg_pending busy=%b active=%0d clk_out=%b want 1/10000/1",
                     busy, period_active_1000, clk_out);
        else n_pass++;
        for (int m = 4; m <= 9; m++) begin
            step();
            n_checks++;
            if (clk_out !== model_level(10000, m))
                $display("FAIL chg_old_wave m=%0d clk_out=%b", m, clk_out);
            else n_pass++;
        end
        prev = clk_out;
        rises = 0;
        for (int m = 10; m < 140; m++) begin
            step();
            if (!prev && clk_out) rises++;
            prev = clk_out;
            n_checks++;
            if (clk_out !== model_level(13000, m - 10))
                $display("FAIL chg_new_wave m=%0d clk_out=%b", m, clk_out);
            else n_pass++;
            if (m == 10) begin
                n_checks++;
                if (period_active_1000 !== 32'd13000 || busy !== 1'b0)
                    $display("FAIL chg_apply active=%0d busy=%b want 13000/0", period_active_1000, busy);
                else n_pass++;
            end
        end
        n_checks++;
        if (rises !== 10) $display("FAIL chg_rises got %0d want 10", rises);
        else n_pass++;
    endtask

    task automatic test_err_and_stop();
        start_period(32'd10000);
        step();
        do_load(32'd1500);
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b0 || period_active_1000 !== 32'd10000)
            $display("FAIL err_pulse err=%b busy=%b active=%0d want 1/0/10000", err, busy, period_active_1000);
        else n_pass++;
        step();
        n_checks++;
        if (err !== 1'b0) $display("FAIL err_clear err=%b want 0", err);
        else n_pass++;
        do_load(32'd0);
        n_checks++;
        if (busy !== 1'b1 || err !== 1'b0) $display("FAIL stop_pending busy=%b err=%b want 1/0", busy, err);
        else n_pass++;
        for (int m = 5; m <= 9; m++) begin
            step();
            n_checks++;
            if (clk_out !== model_level(10000, m))
                $display("FAIL stop_finish m=%0d clk_out=%b", m, clk_out);
            else n_pass++;
        end
        for (int m = 10; m <= 15; m++) begin
            step();
            n_checks++;
            if (clk_out !== 1'b0 || period_active_1000 !== '0 || busy !== 1'b0)
                $display("FAIL stop_idle m=%0d clk_out=%b active=%0d busy=%b", m, clk_out, period_active_1000, busy);
            else n_pass++;
        end
        do_load(32'd1999);
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b0) $display("FAIL err_1999 err=%b busy=%b want 1/0", err, busy);
        else n_pass++;
        do_load(32'd2000);
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b1) $display("FAIL min_2000 err=%b busy=%b want 0/1", err, busy);
        else n_pass++;
        for (int m = 0; m < 8; m++) begin
            step();
            n_checks++;
            if (clk_out !== model_level(2000, m) || period_active_1000 !== 32'd2000)
                $display("FAIL min_wave m=%0d clk_out=%b active=%0d", m, clk_out, period_active_1000);
            else n_pass++;
        end
    endtask

    task automatic test_pwrdwn();
        int len;
        start_period(32'd10000);
        step(); step();
        PWRDWN = 1'b1;
        step();
        n_checks++;
        if (clk_out !== 1'b0) $display("FAIL pwrdwn_low clk_out=%b want 0", clk_out);
        else n_pass++;
        step(); step();
        n_checks++;
        if (clk_out !== 1'b0 || period_active_1000 !== 32'd10000)
            $display("FAIL pwrdwn_hold clk_out=%b active=%0d want 0/10000", clk_out, period_active_1000);
        else n_pass++;
        PWRDWN = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            n_checks++;
            if (clk_out !== ((i == 5) ? 1'b1 : 1'b0))
                $display("FAIL pwrdwn_resume i=%0d clk_out=%b", i, clk_out);
            else n_pass++;
        end
        len = 0;
        for (int i = 1; i <= 40; i++) begin
            logic prev;
            prev = clk_out;
            step();
            if (len == 0 && !prev && clk_out) len = i;
        end
        n_checks++;
        if (len * 1000 !== 10000) $display("FAIL loopback_period got %0d want 10000", len * 1000);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int unsigned per;
            int n;
            per = $urandom_range(25000, 2000);
            start_period(per);
            n = 3 * int'(per) / 1000 + 3;
            for (int m = 1; m <= n; m++) begin
                step();
                n_checks++;
                if (clk_out !== model_level(longint'(per), m))
                    $display("FAIL rand_wave per=%0d m=%0d clk_out=%b", per, m, clk_out);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_10000();
        test_3000();
        test_2500();
        test_change_mid_high();
        test_err_and_stop();
        test_pwrdwn();
        test_random();
        // Asynchronous reset mid-run with busy and err both set.
        start_period(32'd10000);
        step();
        do_load(32'd20000);
        do_load(32'd1500);
        #2;
        RST_N = 1'b0;
        #1;
        n_checks++;
        if (clk_out !== 1'b0 || period_active_1000 !== '0 || busy !== 1'b0 || err !== 1'b0)
            $display("FAIL reset_midrun clk_out=%b active=%0d busy=%b err=%b want all 0",
                     clk_out, period_active_1000, busy, err);
        else n_pass++;
        #2;
        RST_N = 1'b1;
        step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
